// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The entry PC width below must match the fetch_stage BUS_DATA_WIDTH parameter.
package fetch_pkg;

    localparam int          FETCH_ADDR_W = 64;
    localparam logic [31:0] NOP_INS      = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [31:0]             ins;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] cnt, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch entries with push/pop/clear and occupancy count.
module fetch_fifo import fetch_pkg::*; #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop && (count_r != ZERO_CNT);
        do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_CNT;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= ZERO_CNT;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, credit-limited bus requests, redirect squash and decode buffer.
// Optional feature macro: FETCH_PERF_COUNTERS_EN adds fetched/squash/stall counters and their ports.
module fetch_stage import fetch_pkg::*; #(
    parameter int                        BUS_DATA_WIDTH = FETCH_ADDR_W,
    parameter int                        FIFO_DEPTH     = 4,
    parameter logic [BUS_DATA_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inRedirect,
    input  logic [BUS_DATA_WIDTH-1:0] inRedirectPc,
    input  logic                      inStall,
    output logic                      outReqValid,
    output logic [BUS_DATA_WIDTH-1:0] outReqAddr,
    input  logic                      inReqReady,
    input  logic                      inRespValid,
    input  logic [31:0]               inRespData,
    output logic [BUS_DATA_WIDTH-1:0] outPc,
    output logic [31:0]               outIns,
    output logic                      outValid
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]               outFetchedCnt,
    output logic [31:0]               outSquashCnt,
    output logic [31:0]               outStallCnt
`endif
);

    localparam int                        CNT_W        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]          ZERO_CNT     = {CNT_W{1'b0}};
    localparam logic [CNT_W:0]            CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [BUS_DATA_WIDTH-1:0] PC_STEP      = BUS_DATA_WIDTH'(4);
    localparam logic [BUS_DATA_WIDTH-1:0] ALIGN_MASK   = ~BUS_DATA_WIDTH'(3);
    localparam logic [1:0]                ST_BOOT      = BOOT;
    localparam logic [1:0]                ST_RUN       = RUN;
    localparam logic [1:0]                ST_DRAIN     = DRAIN;

    logic [1:0]                state_r, state_nxt_s;
    logic [BUS_DATA_WIDTH-1:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [BUS_DATA_WIDTH-1:0] resp_pc_r, resp_pc_nxt_s;
    logic [CNT_W-1:0]          outstanding_r, outstanding_nxt_s;
    logic [CNT_W-1:0]          drop_cnt_r, drop_cnt_nxt_s;
    logic [CNT_W-1:0]          fifo_count_s;
    logic [CNT_W:0]            occupancy_s;
    logic                      accept_s, resp_s, drop_s, push_s, pop_s, fifo_valid_s;
    fetch_entry_t              push_entry_s, head_s;

    assign push_entry_s = '{pc: resp_pc_r, ins: inRespData};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (inRedirect),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

    // Buffer slots plus in-flight requests form the credit pool, so a returning word always has room.
    always_comb begin
        occupancy_s  = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
        outReqValid  = (state_r != ST_BOOT) && !inRedirect && (occupancy_s < CREDIT_LIMIT);
        outReqAddr   = fetch_pc_r;
        accept_s     = outReqValid && inReqReady;
        resp_s       = inRespValid && (outstanding_r != ZERO_CNT);
        drop_s       = resp_s && !inRedirect && (drop_cnt_r != ZERO_CNT);
        push_s       = resp_s && !inRedirect && (drop_cnt_r == ZERO_CNT);
        fifo_valid_s = (fifo_count_s != ZERO_CNT);
        pop_s        = fifo_valid_s && !inStall && !inRedirect;
    end

    // Decode view of the buffer head, presenting a NOP while empty.
    always_comb begin
        outValid = fifo_valid_s;
        if (fifo_valid_s) begin
            outPc  = head_s.pc;
            outIns = head_s.ins;
        end else begin
            outPc  = {BUS_DATA_WIDTH{1'b0}};
            outIns = NOP_INS;
        end
    end

    // Redirect restarts both PCs and turns every surviving in-flight request into one to drop.
    always_comb begin
        fetch_pc_nxt_s    = fetch_pc_r;
        resp_pc_nxt_s     = resp_pc_r;
        outstanding_nxt_s = outstanding_r;
        drop_cnt_nxt_s    = drop_cnt_r;
        state_nxt_s       = state_r;
        if (inRedirect) begin
            fetch_pc_nxt_s    = inRedirectPc & ALIGN_MASK;
            resp_pc_nxt_s     = inRedirectPc & ALIGN_MASK;
            drop_cnt_nxt_s    = outstanding_r - CNT_W'(resp_s);
            outstanding_nxt_s = outstanding_r - CNT_W'(resp_s);
        end else begin
            if (accept_s) begin
                fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (push_s) begin
                resp_pc_nxt_s = resp_pc_r + PC_STEP;
            end else begin
                resp_pc_nxt_s = resp_pc_r;
            end
            outstanding_nxt_s = outstanding_r + CNT_W'(accept_s) - CNT_W'(resp_s);
            drop_cnt_nxt_s    = drop_cnt_r - CNT_W'(drop_s);
        end
        case (state_r)
            ST_BOOT:  state_nxt_s = ST_RUN;
            ST_RUN,
            ST_DRAIN: state_nxt_s = (drop_cnt_nxt_s != ZERO_CNT) ? ST_DRAIN : ST_RUN;
            default:  state_nxt_s = ST_BOOT;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_BOOT;
            fetch_pc_r    <= RESET_PC;
            resp_pc_r     <= RESET_PC;
            outstanding_r <= ZERO_CNT;
            drop_cnt_r    <= ZERO_CNT;
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            resp_pc_r     <= resp_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            drop_cnt_r    <= drop_cnt_nxt_s;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetched_cnt_r, squash_cnt_r, stall_cnt_r;
    logic [31:0] squash_inc_s;

    // Squashed work: dropped stale responses, or on redirect the flushed entries plus any response that cycle.
    always_comb begin
        if (inRedirect) begin
            squash_inc_s = 32'(fifo_count_s) + 32'(resp_s);
        end else begin
            squash_inc_s = 32'(drop_s);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_cnt_r <= 32'd0;
            squash_cnt_r  <= 32'd0;
            stall_cnt_r   <= 32'd0;
        end else begin
            fetched_cnt_r <= sat_add32(fetched_cnt_r, 32'(push_s));
            squash_cnt_r  <= sat_add32(squash_cnt_r, squash_inc_s);
            stall_cnt_r   <= sat_add32(stall_cnt_r, 32'(fifo_valid_s && inStall));
        end
    end

    assign outFetchedCnt = fetched_cnt_r;
    assign outSquashCnt  = squash_cnt_r;
    assign outStallCnt   = stall_cnt_r;
`endif

endmodule
